// File: rtl/mull_pkg.sv
// Shared constants, mode encodings and the per-lane boolean kernel for mull_lanes_pipe.
package mull_pkg;
   localparam int MULL_LANES_DEF  = 4;
   localparam int MULL_LANES_MIN  = 1;
   localparam int MULL_LANES_MAX  = 32;
   localparam int MULL_STAGES_DEF = 2;
   localparam int MULL_STAGES_MIN = 1;
   localparam int MULL_STAGES_MAX = 4;
   localparam int MULL_CNT_W      = 16;

   typedef enum logic {
      MULL_MODE_NAND = 1'b0,
      MULL_MODE_AND  = 1'b1
   } mull_mode_e;

   // One lane: (y0 & l) optionally inverted, then XORed with zf.
   function automatic logic mull_bit(input mull_mode_e mode, input logic y0,
                                     input logic zf, input logic l_bit);
      logic prod;
      prod = y0 & l_bit;
      if (mode == MULL_MODE_NAND) prod = ~prod;
      return prod ^ zf;
   endfunction
endpackage

// File: rtl/mull_stage.sv
// One pipeline slice: valid flag plus W data bits with load, hold and flush-clear.
module mull_stage
   import mull_pkg::*;
#(
   parameter int W = MULL_LANES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         load,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         valid,
   output logic [W-1:0] data
);
   logic         valid_reg;
   logic [W-1:0] data_reg;

   // Data is only captured with a real beat so a stalled output never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= in_valid;
         if (in_valid) data_reg <= in_data;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
endmodule

// File: rtl/mull_lanes_pipe.sv
// Per-lane NAND/AND-XOR kernel followed by an elastic STAGES-deep pipeline.
// Define MULL_BEAT_CNT_EN to add the saturating beat_cnt retired-beat counter.
module mull_lanes_pipe
   import mull_pkg::*;
#(
   parameter int LANES  = MULL_LANES_DEF,
   parameter int STAGES = MULL_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             zf,
   input  logic             y0,
   input  logic [LANES-1:0] l,
   input  logic             mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] k
`ifdef MULL_BEAT_CNT_EN
   ,
   output logic [MULL_CNT_W-1:0] beat_cnt
`endif
);
   logic [LANES-1:0]  calc;
   logic [STAGES-1:0] stg_valid;
   logic [LANES-1:0]  stg_data [STAGES];
   logic [STAGES:0]   ready_chain;
   logic              run_reg;
   logic              accept;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_reg <= 1'b0;
      else        run_reg <= 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign calc[gi] = mull_bit(mull_mode_e'(mode), y0, zf, l[gi]);
      end
   endgenerate

   // A stage may load when empty or when everything downstream of it drains.
   assign ready_chain[STAGES] = out_ready;
   assign in_ready = run_reg & ~flush & ready_chain[0];
   assign accept   = in_valid & in_ready;

   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         assign ready_chain[gi] = ~stg_valid[gi] | ready_chain[gi+1];
         if (gi == 0) begin : g_first
            mull_stage #(.W(LANES)) u_stage (
               .clk      (clk),
               .rst_n    (rst_n),
               .flush    (flush),
               .load     (ready_chain[gi]),
               .in_valid (accept),
               .in_data  (calc),
               .valid    (stg_valid[gi]),
               .data     (stg_data[gi])
            );
         end else begin : g_rest
            mull_stage #(.W(LANES)) u_stage (
               .clk      (clk),
               .rst_n    (rst_n),
               .flush    (flush),
               .load     (ready_chain[gi]),
               .in_valid (stg_valid[gi-1]),
               .in_data  (stg_data[gi-1]),
               .valid    (stg_valid[gi]),
               .data     (stg_data[gi])
            );
         end
      end
   endgenerate

   assign out_valid = stg_valid[STAGES-1];
   assign k         = stg_data[STAGES-1];

`ifdef MULL_BEAT_CNT_EN
   logic [MULL_CNT_W-1:0] beat_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         beat_cnt_reg <= '0;
      else if (flush)
         beat_cnt_reg <= '0;
      else if (out_valid && out_ready && (beat_cnt_reg != {MULL_CNT_W{1'b1}}))
         beat_cnt_reg <= beat_cnt_reg + 1'b1;
   end

   assign beat_cnt = beat_cnt_reg;
`endif
endmodule

// File: tb/tb_mull_lanes_pipe.sv
// Scoreboard bench for mull_lanes_pipe (LANES=4, STAGES=2); beat_cnt checks with MULL_BEAT_CNT_EN.
module tb_mull_lanes_pipe;
   localparam int LANES  = 4;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             zf = 1'b0;
   logic             y0 = 1'b0;
   logic             mode = 1'b0;
   logic             flush = 1'b0;
   logic             out_ready = 1'b0;
   logic [LANES-1:0] l = '0;
   logic             in_ready;
   logic             out_valid;
   logic [LANES-1:0] k;
`ifdef MULL_BEAT_CNT_EN
   logic [15:0]      beat_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [LANES-1:0] exp_q[$];

   mull_lanes_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .zf        (zf),
      .y0        (y0),
      .l         (l),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .k         (k)
`ifdef MULL_BEAT_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [LANES-1:0] model(input logic m, input logic y, input logic z,
                                              input logic [LANES-1:0] lv);
      logic [LANES-1:0] r;
      for (int i = 0; i < LANES; i++) begin
         r[i] = m ? ((y & lv[i]) ^ z) : (~(y & lv[i]) ^ z);
      end
      return r;
   endfunction

   task automatic test_reset();
      #2;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      n_checks++; if (k !== 4'b0000) begin n_fail++; $display("FAIL reset_k got=%b want=0000", k); end
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre got=%b want=0", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_post got=%b want=1", in_ready); end
      $display("reset: done");
   endtask

   task automatic test_latency();
      @(negedge clk);
      in_valid = 1'b1; mode = 1'b0; y0 = 1'b1; l = 4'b1010; zf = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got=%b want=1", in_ready); end
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got=%b want=0", out_valid); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_out_valid got=%b want=1", out_valid); end
      n_checks++; if (k !== 4'b0101) begin n_fail++; $display("FAIL lat_k got=%b want=0101", k); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_dup got=%b want=0", out_valid); end
      $display("latency: beat k=0101 after 2 cycles");
   endtask

   task automatic test_modes();
      logic             m_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic             y_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic             z_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [LANES-1:0] l_t  [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0011, 4'b1111};
      logic [LANES-1:0] e_t  [6] = '{4'b0101, 4'b1111, 4'b0101, 4'b0110, 4'b0011, 4'b1111};
      logic [LANES-1:0] e;
      bit got;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         in_valid = 1'b1; mode = m_t[t]; y0 = y_t[t]; zf = z_t[t]; l = l_t[t]; out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) exp_q.push_back(e_t[t]);
         @(posedge clk);
         got = 1'b0;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid && out_ready) begin
               got = 1'b1;
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL mode_spurious case=%0d got=%b want=none", t, k);
               end else begin
                  e = exp_q.pop_front();
                  if (k !== e) begin n_fail++; $display("FAIL mode_k case=%0d got=%b want=%b", t, k, e); end
               end
            end
         end
         if (!got) begin n_checks++; n_fail++; $display("FAIL mode_timeout case=%0d got=no beat want=beat", t); end
         $display("mode case %0d: mode=%b y0=%b zf=%b l=%b k=%b", t, m_t[t], y_t[t], z_t[t], l_t[t], k);
      end
   endtask

   task automatic test_back_to_back();
      bit               pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int               sent = 0;
      int               got = 0;
      bit               stall_prev = 1'b0;
      logic [LANES-1:0] k_prev = '0;
      logic [LANES-1:0] e;
      bit               exp_rdy;
      for (int c = 0; c < 100 && got < 8; c++) begin
         @(negedge clk);
         out_ready = pat[c % 4];
         in_valid  = (sent < 8);
         mode = 1'($urandom_range(0, 1)); y0 = 1'($urandom_range(0, 1));
         zf   = 1'($urandom_range(0, 1)); l  = 4'($urandom_range(0, 15));
         #1;
         if (stall_prev) begin
            n_checks++;
            if (out_valid !== 1'b1 || k !== k_prev) begin
               n_fail++; $display("FAIL b2b_stall_hold cyc=%0d got=%b/%b want=1/%b", c, out_valid, k, k_prev);
            end
         end
         exp_rdy = !((exp_q.size() == STAGES) && !out_ready);
         n_checks++;
         if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", c, in_ready, exp_rdy); end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_spurious cyc=%0d got=%b want=none", c, k);
            end else begin
               e = exp_q.pop_front();
               if (k !== e) begin n_fail++; $display("FAIL b2b_k cyc=%0d got=%b want=%b", c, k, e); end
            end
            $display("b2b: retired beat %0d k=%b", got, k);
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(mode, y0, zf, l));
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         k_prev = k;
      end
      @(negedge clk); in_valid = 1'b0;
      n_checks++;
      if (got != 8 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL b2b_count got=%0d left=%0d want=8/0", got, exp_q.size());
      end
   endtask

   task automatic fill_two(input logic [LANES-1:0] la, input logic [LANES-1:0] lb);
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; mode = 1'b0; y0 = 1'b1; zf = 1'b0; l = la;
      @(negedge clk); mode = 1'b1; l = lb;
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_two(4'b1010, 4'b1100);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_ready got=%b want=0", in_ready); end
      @(negedge clk); in_valid = 1'b1; flush = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after got=%b want=1", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak cyc=%0d got=%b want=0", c, out_valid); end
      end
      $display("flush: two in-flight beats discarded");
      // flush on the same cycle as a retiring handshake
      fill_two(4'b1010, 4'b1100);
      @(negedge clk); out_ready = 1'b1; flush = 1'b1; #1;
      n_checks++;
      if (out_valid !== 1'b1 || k !== 4'b0101) begin
         n_fail++; $display("FAIL flush_hs_seen got=%b/%b want=1/0101", out_valid, k);
      end
      @(negedge clk); flush = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hs_rest got=%b want=0", out_valid); end
      $display("flush: coincident handshake retired head beat only");
   endtask

   task automatic test_reset_mid();
      fill_two(4'b0110, 4'b1001);
      #2; rst_n = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
      n_checks++; if (k !== 4'b0000) begin n_fail++; $display("FAIL rstmid_k got=%b want=0000", k); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=0", in_ready); end
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_pre got=%b want=0", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_post got=%b want=1", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_leak cyc=%0d got=%b want=0", c, out_valid); end
      end
      $display("reset mid-stream: in-flight beats discarded");
   endtask

`ifdef MULL_BEAT_CNT_EN
   task automatic send_beats(input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); in_valid = 1'b1; l = 4'($urandom_range(0, 15));
      end
      @(negedge clk); in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic test_beat_cnt();
      #1;
      n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_start got=%0d want=0", beat_cnt); end
      send_beats(5);
      n_checks++; if (beat_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_five got=%0d want=5", beat_cnt); end
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0; #1;
      n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_flush got=%0d want=0", beat_cnt); end
      @(negedge clk);
      force dut.beat_cnt_reg = 16'hFFFD;
      #1;
      release dut.beat_cnt_reg;
      send_beats(4);
      n_checks++; if (beat_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat got=%h want=ffff", beat_cnt); end
      $display("beat_cnt: count, flush and saturation exercised");
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_modes();
      test_back_to_back();
      test_flush();
      test_reset_mid();
`ifdef MULL_BEAT_CNT_EN
      test_beat_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
